// File: rtl/basemul_unit.sv
// basemul_unit: ML-KEM BaseCaseMultiply on one time-shared mod_mul, results finished with modular adds.
// Optional build macro BASEMUL_ACC_EN adds acc_i accumulate mode (one extra cycle).
module mod_mul #(
  parameter int Q = 3329,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        valid_i,
  output logic [11:0] r,
  output logic        valid_o
);
  logic [LAT-1:0] v;
  logic [23:0]    prod;
  logic [11:0]    pipe [LAT-1];
  always_ff @(posedge clk) begin
    if (rst) v <= '0;
    else v <= {v[LAT-2:0], valid_i};
    prod <= a * b;
    pipe[0] <= 12'(prod % 24'(Q));
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign r = pipe[LAT-2];
  assign valid_o = v[LAT-1];
endmodule

module basemul_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] a0_i,
  input  logic [11:0] a1_i,
  input  logic [11:0] b0_i,
  input  logic [11:0] b1_i,
  input  logic [11:0] zeta_i,
  input  logic        valid_i,
`ifdef BASEMUL_ACC_EN
  input  logic        acc_i,
`endif
  output logic        ready_o,
  output logic [11:0] c0_o,
  output logic [11:0] c1_o,
  output logic        valid_o,
  input  logic        ready_i
);
  localparam int Q = 3329;
  localparam int LAT = 2;
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT,
`ifdef BASEMUL_ACC_EN
    ACC,
`endif
    OUT
  } state_t;
  state_t state, nxt, wait_nxt;
  logic [11:0] a0, a1, b0, b1, zeta, p0, p1, p2, p3, c0, c1, mm_a, mm_b, mm_r;
  logic [2:0]  cnt, ret;
  logic        mm_v, mm_valid, done;
`ifdef BASEMUL_ACC_EN
  logic        acc_q;
  logic [11:0] s0, s1;
`endif
  function automatic logic [11:0] modadd(input logic [11:0] x, input logic [11:0] y);
    logic [12:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s >= 13'(Q) ? 12'(s - 13'(Q)) : s[11:0];
  endfunction
  mod_mul #(.Q(Q), .LAT(LAT)) u_mm (
    .clk(clk), .rst(rst), .a(mm_a), .b(mm_b), .valid_i(mm_v), .r(mm_r), .valid_o(mm_valid)
  );
  // Fixed issue order k0..k4; p1 is back well before k4 reuses it with zeta.
  always_comb begin
    mm_a = cnt == 3'd0 || cnt == 3'd3 ? a1 : cnt == 3'd4 ? p1 : a0;
    mm_b = cnt == 3'd0 || cnt == 3'd2 ? b1 : cnt == 3'd4 ? zeta : b0;
  end
  assign mm_v = state == ISSUE;
  assign done = mm_valid && ret == 3'd4;
`ifdef BASEMUL_ACC_EN
  assign wait_nxt = acc_q ? ACC : OUT;
`else
  assign wait_nxt = OUT;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = valid_i ? ISSUE : IDLE;
      ISSUE:   nxt = cnt == 3'd4 ? WAIT : ISSUE;
      WAIT:    nxt = done ? wait_nxt : WAIT;
`ifdef BASEMUL_ACC_EN
      ACC:     nxt = OUT;
`endif
      OUT:     nxt = ready_i ? IDLE : OUT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ret <= '0;
      c0 <= '0;
      c1 <= '0;
`ifdef BASEMUL_ACC_EN
      acc_q <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && valid_i) begin
        cnt <= '0;
        ret <= '0;
`ifdef BASEMUL_ACC_EN
        acc_q <= acc_i;
`endif
      end
      if (state == ISSUE) cnt <= cnt + 3'd1;
      if (mm_valid) ret <= ret + 3'd1;
`ifdef BASEMUL_ACC_EN
      if (done && acc_q) begin
        s0 <= modadd(p0, mm_r);
        s1 <= modadd(p2, p3);
      end else if (done) begin
        c0 <= modadd(p0, mm_r);
        c1 <= modadd(p2, p3);
      end
      if (state == ACC) begin
        c0 <= modadd(c0, s0);
        c1 <= modadd(c1, s1);
      end
`else
      if (done) begin
        c0 <= modadd(p0, mm_r);
        c1 <= modadd(p2, p3);
      end
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && valid_i) begin
      a0 <= a0_i;
      a1 <= a1_i;
      b0 <= b0_i;
      b1 <= b1_i;
      zeta <= zeta_i;
    end
    if (mm_valid && ret == 3'd0) p1 <= mm_r;
    if (mm_valid && ret == 3'd1) p0 <= mm_r;
    if (mm_valid && ret == 3'd2) p2 <= mm_r;
    if (mm_valid && ret == 3'd3) p3 <= mm_r;
  end
  assign ready_o = state == IDLE;
  assign valid_o = state == OUT;
  assign c0_o = c0;
  assign c1_o = c1;
endmodule

// File: tb/tb_basemul_unit.sv
// tb_basemul_unit: directed and random pairs checked against a plain-arithmetic BaseCaseMultiply model.
module tb_basemul_unit;
  localparam int Q = 3329;
`ifdef BASEMUL_ACC_EN
  localparam bit ACC_BUILD = 1'b1;
`else
  localparam bit ACC_BUILD = 1'b0;
`endif
  logic clk = 1'b0, rst, valid_i, ready_i, ready_o, valid_o, acc_i;
  logic [11:0] a0_i, a1_i, b0_i, b1_i, zeta_i, c0_o, c1_o;
  int errors = 0, checks = 0, prev0 = 0, prev1 = 0;
  always #5 clk = ~clk;
  basemul_unit dut (
    .clk(clk), .rst(rst), .a0_i(a0_i), .a1_i(a1_i), .b0_i(b0_i), .b1_i(b1_i),
    .zeta_i(zeta_i), .valid_i(valid_i),
`ifdef BASEMUL_ACC_EN
    .acc_i(acc_i),
`endif
    .ready_o(ready_o), .c0_o(c0_o), .c1_o(c1_o), .valid_o(valid_o), .ready_i(ready_i)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic scramble;
    a0_i = 12'($urandom_range(0, Q - 1));
    a1_i = 12'($urandom_range(0, Q - 1));
    b0_i = 12'($urandom_range(0, Q - 1));
    b1_i = 12'($urandom_range(0, Q - 1));
    zeta_i = 12'($urandom_range(0, Q - 1));
  endtask
  task automatic do_pair(input int x0, input int x1, input int y0, input int y1, input int z,
                         input bit acc, input int hold);
    int k, e0, e1, lat;
    logic [11:0] h0, h1;
    e0 = (x0 * y0 + ((x1 * y1) % Q) * z) % Q;
    e1 = (x0 * y1 + x1 * y0) % Q;
    if (ACC_BUILD && acc) begin
      e0 = (prev0 + e0) % Q;
      e1 = (prev1 + e1) % Q;
    end
    lat = (ACC_BUILD && acc) ? 8 : 7;
    chk("ready_idle", ready_o, 1);
    a0_i = 12'(x0); a1_i = 12'(x1); b0_i = 12'(y0); b1_i = 12'(y1); zeta_i = 12'(z);
    acc_i = acc;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    acc_i = 1'b0;
    scramble();
    k = 0;
    while (!valid_o && k < 20) begin
      chk("ready_busy", ready_o, 0);
      step();
      k++;
    end
    chk("latency", k, lat);
    chk("c0", c0_o, e0);
    chk("c1", c1_o, e1);
    prev0 = e0;
    prev1 = e1;
    if (hold > 0) begin
      ready_i = 1'b0;
      h0 = c0_o;
      h1 = c1_o;
      a0_i = 12'd7; a1_i = 12'd9; b0_i = 12'd11; b1_i = 12'd13; zeta_i = 12'd17;
      valid_i = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        chk("bp_valid", valid_o, 1);
        chk("bp_ready", ready_o, 0);
        chk("bp_c0", c0_o, h0);
        chk("bp_c1", c1_o, h1);
      end
      ready_i = 1'b1;
    end
    step();
    chk("valid_drop", valid_o, 0);
    chk("ready_back", ready_o, 1);
  endtask
  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; acc_i = 1'b0;
    a0_i = '0; a1_i = '0; b0_i = '0; b1_i = '0; zeta_i = '0;
    repeat (3) step();
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_c0", c0_o, 0);
    chk("rst_c1", c1_o, 0);
    rst = 1'b0;
    step();
    do_pair(1, 0, 5, 0, 17, 0, 0);
    do_pair(0, 1, 0, 1, 17, 0, 0);
    do_pair(2, 3, 4, 5, 17, 0, 0);
    do_pair(3328, 3328, 3328, 3328, 3328, 0, 0);
    do_pair(100, 2000, 3000, 45, 1234, 0, 10);
    do_pair(7, 9, 11, 13, 17, 0, 0);
    a0_i = 12'd2; a1_i = 12'd3; b0_i = 12'd4; b1_i = 12'd5; zeta_i = 12'd17;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    prev0 = 0;
    prev1 = 0;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_c0", c0_o, 0);
    chk("mid_rst_c1", c1_o, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("no_stale", valid_o, 0);
    end
    do_pair(3000, 1500, 2999, 17, 3100, 0, 0);
    if (ACC_BUILD) begin
      do_pair(1, 0, 5, 0, 17, 0, 0);
      do_pair(3328, 0, 6, 0, 17, 1, 0);
    end
    for (int i = 0; i < 20; i++)
      do_pair(int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
              int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
              int'($urandom_range(0, Q - 1)), ACC_BUILD ? bit'($urandom_range(0, 1)) : 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
